prt_lb_mbox: RTL

// - Local-bus responder: mailbox between the RISC-V CPU and hardware via two 32-bit FIFOs.
// - Sits on one downstream port of the LB mux; write path is CPU->hardware (TX), read path is hardware->CPU (RX).
// - Raises IRQ_OUT toward the CPU interrupt OR-tree when RX data is pending.

---
 rtl/prt_lb_mbox_pkg.sv | 44 ++++
 rtl/prt_dp_lb_if.sv | 15 +
 rtl/prt_lb_mbox_fifo.sv | 73 +++++++
 rtl/prt_lb_mbox.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/prt_lb_mbox_pkg.sv
// Package for the local-bus mailbox: register map, CTL/STA bit positions
// and the packed layout of the status word.
// Optional build macro: PRT_LB_MBOX_ERR_EN (sticky overflow/underflow flags).
package prt_lb_mbox_pkg;

    localparam int MBOX_DAT_W = 32;

    // Word addresses decoded from adr[1:0]
    localparam logic [1:0] MBOX_CTL = 2'd0;
    localparam logic [1:0] MBOX_STA = 2'd1;
    localparam logic [1:0] MBOX_TX  = 2'd2;
    localparam logic [1:0] MBOX_RX  = 2'd3;

    // CTL bit positions
    localparam int CTL_RUN      = 0;
    localparam int CTL_IRQ_EN   = 1;
    localparam int CTL_TX_FLUSH = 2;
    localparam int CTL_RX_FLUSH = 3;

    // STA bit positions
    localparam int STA_IRQ      = 0;
    localparam int STA_TX_FULL  = 1;
    localparam int STA_TX_EMPTY = 2;
    localparam int STA_RX_FULL  = 3;
    localparam int STA_RX_EMPTY = 4;
    localparam int STA_TX_OVF   = 5;
    localparam int STA_RX_UNF   = 6;

    // Status word as seen by the CPU, MSB first
    typedef struct packed {
        logic [7:0] rsvd_hi;
        logic [7:0] rx_cnt;
        logic [7:0] tx_cnt;
        logic       rsvd7;
        logic       rx_unf;
        logic       tx_ovf;
        logic       rx_empty;
        logic       rx_full;
        logic       tx_empty;
        logic       tx_full;
        logic       irq_pend;
    } sta_t;

endpackage

// File: rtl/prt_dp_lb_if.sv
// Local-bus port bundle between the LB mux and its responders.
// The responder samples adr/wr/rd/din and answers every rd with one vld pulse.
interface prt_dp_lb_if #(
    parameter int P_ADR_W = 16
);
    logic [P_ADR_W-1:0] adr;
    logic               wr;
    logic               rd;
    logic [31:0]        din;
    logic [31:0]        dout;
    logic               vld;

    modport lb_in  (input adr, wr, rd, din, output dout, vld);
    modport lb_out (output adr, wr, rd, din, input dout, vld);
endinterface

// File: rtl/prt_lb_mbox_fifo.sv
// Synchronous first-word-fall-through FIFO used for both mailbox directions.
// A push while full is dropped even if a pop happens in the same cycle;
// clr empties the FIFO and overrides any push/pop in that cycle.
module prt_lb_mbox_fifo
    import prt_lb_mbox_pkg::*;
#(
    parameter int P_WRDS = 16,
    parameter int P_DAT  = MBOX_DAT_W,
    localparam int P_ADR = $clog2(P_WRDS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_i,
    input  logic [P_DAT-1:0] din_i,
    input  logic             rd_i,
    input  logic             clr_i,
    output logic [P_DAT-1:0] dout_o,
    output logic [P_ADR:0]   cnt_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [P_DAT-1:0] mem_q [P_WRDS];
    logic [P_ADR-1:0] wptr_q, wptr_d;
    logic [P_ADR-1:0] rptr_q, rptr_d;
    logic [P_ADR:0]   cnt_q, cnt_d;
    logic             push, pop;

    // Depth is a power of two, so the count MSB alone marks "full"
    assign full_o  = cnt_q[P_ADR];
    assign empty_o = (cnt_q == '0);
    assign cnt_o   = cnt_q;
    assign dout_o  = mem_q[rptr_q];

    assign push = wr_i && !full_o;
    assign pop  = rd_i && !empty_o;

    // Next pointer/count; a flush wins over the same-cycle push and pop
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
            if (push && !pop) cnt_d = cnt_q + 1'b1;
            if (pop && !push) cnt_d = cnt_q - 1'b1;
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage array; contents need no reset since the count guards them
    always_ff @(posedge clk_i) begin
        if (push && !clr_i) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/prt_lb_mbox.sv
// Local-bus mailbox between the CPU and hardware: TX FIFO (CPU -> hw stream)
// and RX FIFO (hw stream -> CPU), a small CTL/STA register pair and an IRQ.
// Optional build macro: PRT_LB_MBOX_ERR_EN adds sticky TX-overflow and
// RX-underflow flags (write-1-to-clear) that also feed the interrupt.
module prt_lb_mbox
    import prt_lb_mbox_pkg::*;
#(
    parameter int P_FIFO_WRDS = 16,
    localparam int P_FIFO_ADR = $clog2(P_FIFO_WRDS)
) (
    input  logic                CLK_IN,
    input  logic                RST_IN,
    prt_dp_lb_if.lb_in          LB_IF,
    output logic [31:0]         TX_DAT_OUT,
    output logic                TX_VLD_OUT,
    input  logic                TX_RDY_IN,
    input  logic [31:0]         RX_DAT_IN,
    input  logic                RX_VLD_IN,
    output logic                RX_RDY_OUT,
    output logic                IRQ_OUT
);

    logic               run_q, run_d;
    logic               irq_en_q, irq_en_d;
    logic               irq_q, irq_d;
    logic               vld_q, vld_d;
    logic [31:0]        dout_q, dout_d;

    logic [1:0]         reg_adr;
    logic               wr_en, ctl_wr, tx_wr, rx_rd;
    logic               tx_flush, rx_flush;
    logic               tx_full, tx_empty, rx_full, rx_empty;
    logic [P_FIFO_ADR:0] tx_cnt, rx_cnt;
    logic [31:0]        rx_head;
    logic               tx_ovf, rx_unf, err_pend;
    sta_t               sta;
    logic [31:0]        rdata;

    // A read in the same cycle as a write takes the bus; the write is lost
    assign reg_adr  = LB_IF.adr[1:0];
    assign wr_en    = LB_IF.wr && !LB_IF.rd;
    assign ctl_wr   = wr_en && (reg_adr == MBOX_CTL);
    assign tx_wr    = wr_en && (reg_adr == MBOX_TX);
    assign rx_rd    = LB_IF.rd && (reg_adr == MBOX_RX);
    assign tx_flush = ctl_wr && LB_IF.din[CTL_TX_FLUSH];
    assign rx_flush = ctl_wr && LB_IF.din[CTL_RX_FLUSH];

    assign TX_VLD_OUT = run_q && !tx_empty;
    assign RX_RDY_OUT = run_q && !rx_full;
    assign IRQ_OUT    = irq_q;
    assign LB_IF.dout = dout_q;
    assign LB_IF.vld  = vld_q;

    prt_lb_mbox_fifo #(.P_WRDS(P_FIFO_WRDS), .P_DAT(32)) u_tx_fifo (
        .clk_i   (CLK_IN),
        .rst_i   (RST_IN),
        .wr_i    (tx_wr),
        .din_i   (LB_IF.din),
        .rd_i    (TX_VLD_OUT && TX_RDY_IN),
        .clr_i   (tx_flush),
        .dout_o  (TX_DAT_OUT),
        .cnt_o   (tx_cnt),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    prt_lb_mbox_fifo #(.P_WRDS(P_FIFO_WRDS), .P_DAT(32)) u_rx_fifo (
        .clk_i   (CLK_IN),
        .rst_i   (RST_IN),
        .wr_i    (RX_VLD_IN && RX_RDY_OUT),
        .din_i   (RX_DAT_IN),
        .rd_i    (rx_rd),
        .clr_i   (rx_flush),
        .dout_o  (rx_head),
        .cnt_o   (rx_cnt),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

`ifdef PRT_LB_MBOX_ERR_EN
    logic sta_wr;
    logic tx_ovf_q, tx_ovf_d;
    logic rx_unf_q, rx_unf_d;

    assign sta_wr = wr_en && (reg_adr == MBOX_STA);

    // Sticky error flags: W1C through STA, set by a dropped push or empty pop
    always_comb begin
        tx_ovf_d = tx_ovf_q;
        rx_unf_d = rx_unf_q;
        if (sta_wr && LB_IF.din[STA_TX_OVF]) tx_ovf_d = 1'b0;
        if (sta_wr && LB_IF.din[STA_RX_UNF]) rx_unf_d = 1'b0;
        if (tx_wr && tx_full)  tx_ovf_d = 1'b1;
        if (rx_rd && rx_empty) rx_unf_d = 1'b1;
    end

    // Error flag registers
    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            tx_ovf_q <= 1'b0;
            rx_unf_q <= 1'b0;
        end else begin
            tx_ovf_q <= tx_ovf_d;
            rx_unf_q <= rx_unf_d;
        end
    end

    assign tx_ovf   = tx_ovf_q;
    assign rx_unf   = rx_unf_q;
    assign err_pend = tx_ovf_q || rx_unf_q;
`else
    assign tx_ovf   = 1'b0;
    assign rx_unf   = 1'b0;
    assign err_pend = 1'b0;
`endif

    // Assemble the status word from FIFO state and flags
    always_comb begin
        sta          = '0;
        sta.irq_pend = irq_q;
        sta.tx_full  = tx_full;
        sta.tx_empty = tx_empty;
        sta.rx_full  = rx_full;
        sta.rx_empty = rx_empty;
        sta.tx_ovf   = tx_ovf;
        sta.rx_unf   = rx_unf;
        sta.tx_cnt   = 8'(tx_cnt);
        sta.rx_cnt   = 8'(rx_cnt);
    end

    // Read data mux; an RX read on an empty FIFO returns zero
    always_comb begin
        rdata = '0;
        case (reg_adr)
            MBOX_CTL: rdata = {30'd0, irq_en_q, run_q};
            MBOX_STA: rdata = sta;
            MBOX_TX:  rdata = '0;
            MBOX_RX:  rdata = rx_empty ? 32'd0 : rx_head;
            default:  rdata = '0;
        endcase
    end

    // Next state for control bits, read response and interrupt
    always_comb begin
        run_d    = run_q;
        irq_en_d = irq_en_q;
        if (ctl_wr) begin
            run_d    = LB_IF.din[CTL_RUN];
            irq_en_d = LB_IF.din[CTL_IRQ_EN];
        end
        vld_d  = LB_IF.rd;
        dout_d = LB_IF.rd ? rdata : dout_q;
        irq_d  = irq_en_q && (!rx_empty || err_pend);
    end

    // Control, response and interrupt registers
    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            run_q    <= 1'b0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
            vld_q    <= 1'b0;
            dout_q   <= '0;
        end else begin
            run_q    <= run_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
            vld_q    <= vld_d;
            dout_q   <= dout_d;
        end
    end

endmodule
